// File: rtl/shift_pkg.sv
// Shared types and default sizes for the sequential left shifter.
package shift_pkg;

    localparam int unsigned SHL_WIDTH = 4;
    localparam int unsigned SHL_CNT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_left_seq_shl_step.sv
// Single one-bit left step: shifts din left, inserting lsb_in and ejecting the MSB.
module shl_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SHL_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] dout,
    output logic             msb_out
);

    always_comb begin
        dout    = {din[WIDTH-2:0], lsb_in};
        msb_out = din[WIDTH-1];
    end

endmodule

// File: rtl/shift_left_seq.sv
// Sequential left shifter: one bit per clock, done pulse on completion.
// Optional SHIFTL_ROTATE_EN adds a rot input selecting rotate-left instead of fill.
module shift_left_seq
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = SHL_WIDTH,
    parameter int unsigned CNT_W = SHL_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] amt,
    input  logic             fill,
`ifdef SHIFTL_ROTATE_EN
    input  logic             rot,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             fill_q, fill_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lsb_in;
    logic [WIDTH-1:0] step_dout;
    logic             step_msb;

`ifdef SHIFTL_ROTATE_EN
    logic rot_q, rot_d;
    assign lsb_in = rot_q ? out_q[WIDTH-1] : fill_q;
`else
    assign lsb_in = fill_q;
`endif

    shl_step #(.WIDTH(WIDTH)) u_step (
        .din     (out_q),
        .lsb_in  (lsb_in),
        .dout    (step_dout),
        .msb_out (step_msb)
    );

    // Next-state, datapath and registered Moore output decode
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        fill_d  = fill_q;
`ifdef SHIFTL_ROTATE_EN
        rot_d   = rot_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    out_d   = a;
                    cnt_d   = amt;
                    carry_d = 1'b0;
                    fill_d  = fill;
`ifdef SHIFTL_ROTATE_EN
                    rot_d   = rot;
`endif
                    state_d = (amt == CNT_W'(0)) ? ST_DONE : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                out_d   = step_dout;
                carry_d = step_msb;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            fill_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFTL_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            fill_q  <= fill_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SHIFTL_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed bench for shift_left_seq: vector table plus hand-written multi-cycle sequences.
module tb_shift_left_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [1:0] amt;
    logic       fill;
    logic       busy;
    logic       done;
    logic [3:0] out;
    logic       carry;
`ifdef SHIFTL_ROTATE_EN
    logic       rot;
`endif

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [3:0] a;
        logic [1:0] amt;
        logic       fill;
        logic [3:0] eo;
        logic       ec;
    } vec_t;

    vec_t vecs[7];

    shift_left_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .amt   (amt),
        .fill  (fill),
`ifdef SHIFTL_ROTATE_EN
        .rot   (rot),
`endif
        .busy  (busy),
        .done  (done),
        .out   (out),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Issue one request, wait for done (bounded), check result, latency and the idle cycle after
    task automatic run_op(input logic [3:0] a_i, input logic [1:0] amt_i, input logic fill_i,
                          input logic [3:0] exp_o, input logic exp_c, input string nm);
        int n;
        int nb;
        int both;
        logic [3:0] held;
        a = a_i; amt = amt_i; fill = fill_i; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1; nb = 0; both = 0;
        while (!done && n < 12) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        if (busy && done) both = 1;
        check({nm, " latency"}, n, int'(amt_i) + 1);
        check({nm, " busy_cycles"}, nb, int'(amt_i));
        check({nm, " out"}, int'(out), int'(exp_o));
        check({nm, " carry"}, int'(carry), int'(exp_c));
        check({nm, " busy_and_done"}, both, 0);
        held = out;
        @(posedge clk); #1;
        check({nm, " done_pulse_ends"}, int'(done), 0);
        check({nm, " out_holds"}, int'(out), int'(exp_o));
        if (held != exp_o) check({nm, " out_at_done"}, int'(held), int'(exp_o));
    endtask

    initial begin
        int n;
        vecs[0] = '{4'b0001, 2'd3, 1'b0, 4'b1000, 1'b0};
        vecs[1] = '{4'b1000, 2'd1, 1'b0, 4'b0000, 1'b1};
        vecs[2] = '{4'b0010, 2'd0, 1'b0, 4'b0010, 1'b0};
        vecs[3] = '{4'b0000, 2'd2, 1'b1, 4'b0011, 1'b0};
        vecs[4] = '{4'b1011, 2'd2, 1'b1, 4'b1111, 1'b0};
        vecs[5] = '{4'b1101, 2'd3, 1'b0, 4'b1000, 1'b0};
        vecs[6] = '{4'b0110, 2'd1, 1'b1, 4'b1101, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; amt = '0; fill = 1'b0;
`ifdef SHIFTL_ROTATE_EN
        rot = 1'b0;
`endif
        #12;
        check("reset out", int'(out), 0);
        check("reset carry", int'(carry), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].amt, vecs[i].fill, vecs[i].eo, vecs[i].ec,
                   $sformatf("vec%0d", i));
        end

        // start asserted mid-SHIFT with different operands must be ignored
        a = 4'b0001; amt = 2'd3; fill = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 4'b1111; amt = 2'd0; fill = 1'b1;
        @(posedge clk); #1;
        check("ignore_start busy", int'(busy), 1);
        start = 1'b0;
        n = 2;
        while (!done && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check("ignore_start latency", n, 4);
        check("ignore_start out", int'(out), 4'b1000);
        check("ignore_start carry", int'(carry), 0);
        @(posedge clk); #1;

        // back-to-back: start held in the DONE cycle
        a = 4'b0000; amt = 2'd2; fill = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b first latency", n, 3);
        check("b2b first out", int'(out), 4'b0011);
        a = 4'b0001; amt = 2'd1; fill = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b accept out", int'(out), 4'b0001);
        check("b2b accept busy", int'(busy), 1);
        check("b2b accept done", int'(done), 0);
        @(posedge clk); #1;
        check("b2b second done", int'(done), 1);
        check("b2b second out", int'(out), 4'b0010);
        check("b2b second carry", int'(carry), 0);
        @(posedge clk); #1;

        // asynchronous reset mid-SHIFT
        a = 4'b0111; amt = 2'd3; fill = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        check("pre_reset busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("async_rst out", int'(out), 0);
        check("async_rst carry", int'(carry), 0);
        check("async_rst busy", int'(busy), 0);
        check("async_rst done", int'(done), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || busy) n++;
        end
        check("post_reset quiet", n, 0);
        run_op(4'b0111, 2'd3, 1'b0, 4'b1000, 1'b1, "post_reset");

`ifdef SHIFTL_ROTATE_EN
        rot = 1'b1;
        run_op(4'b1001, 2'd1, 1'b0, 4'b0011, 1'b1, "rot1");
        run_op(4'b1001, 2'd3, 1'b0, 4'b1100, 1'b0, "rot3");
        rot = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
